// File: rtl/seg_pkg.sv
// +----------------------------------------------------------------------------+
// | seg_pkg: shared types and constants for the seven-segment display path.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package seg_pkg;

  localparam int DISP_DIGITS = 8;
  localparam int BCD_MAX     = 99_999_999;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } b2b_state_t;

  typedef logic [3:0] bcd_digit_t;

  // Largest value representable in the given number of decimal digits.
  function automatic logic [63:0] bcd_limit(input int digits);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
// +----------------------------------------------------------------------------+
// | bcd_digit_adjust: double-dabble correction, adds 3 to a digit >= 5.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module bcd_digit_adjust
  import seg_pkg::*;
(
  input  bcd_digit_t digit_in,
  output bcd_digit_t digit_out
);

  // Valid digits are 0-9 so the sum tops out at 4'hC and never wraps.
  assign digit_out = (digit_in >= 4'd5) ? bcd_digit_t'(digit_in + 4'd3) : digit_in;

endmodule

`default_nettype wire

// File: rtl/bin2bcd_converter.sv
// +----------------------------------------------------------------------------+
// | bin2bcd_converter: iterative double-dabble, one shift per clock; result   |
// | held stable between conversions and saturated to all 9s on overflow.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module bin2bcd_converter
  import seg_pkg::*;
#(
  parameter int BIN_WIDTH = 27,
  parameter int DIGITS    = DISP_DIGITS
) (
  input  logic                  system_clock,
  input  logic                  cpu_rst_n,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int c_cnt_w = $clog2(BIN_WIDTH + 1);
  localparam int c_bcd_w = 4 * DIGITS;

  localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(BIN_WIDTH);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  // When 10^DIGITS-1 is beyond the input range the compare can never trip.
  localparam logic [63:0]          c_limit64 = bcd_limit(DIGITS);
  localparam logic [BIN_WIDTH:0]   c_limit   =
      (c_limit64 >= (64'd1 << BIN_WIDTH)) ? {(BIN_WIDTH+1){1'b1}} : c_limit64[BIN_WIDTH:0];

  b2b_state_t             r_state;
  logic [BIN_WIDTH-1:0]   r_bin_sr;
  logic [c_bcd_w-1:0]     r_bcd_sr;
  logic [c_cnt_w-1:0]     r_cnt;
  logic                   r_ovf;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_overflow;
  logic [c_bcd_w-1:0]     r_bcd_out;

  logic                   w_ovf;
  logic [c_bcd_w-1:0]     w_bcd_adj;
  logic [c_bcd_w-1:0]     w_bcd_next;

  assign w_ovf = {1'b0, bin_in} > c_limit;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit_adjust
    bcd_digit_adjust u_adjust (
      .digit_in  (r_bcd_sr[4*g +: 4]),
      .digit_out (w_bcd_adj[4*g +: 4])
    );
  end

  assign w_bcd_next = {w_bcd_adj[c_bcd_w-2:0], r_bin_sr[BIN_WIDTH-1]};

  always_ff @(posedge system_clock) begin
    if (!cpu_rst_n) begin
      r_state    <= IDLE;
      r_bin_sr   <= '0;
      r_bcd_sr   <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_bcd_out  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_bin_sr <= bin_in;
            r_bcd_sr <= '0;
            r_cnt    <= c_cnt_load;
            r_ovf    <= w_ovf;
            r_busy   <= 1'b1;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          r_bcd_sr <= w_bcd_next;
          r_bin_sr <= {r_bin_sr[BIN_WIDTH-2:0], 1'b0};
          r_cnt    <= r_cnt - c_cnt_one;
          if (r_cnt == c_cnt_one) begin
            r_bcd_out  <= r_ovf ? {DIGITS{4'h9}} : w_bcd_next;
            r_overflow <= r_ovf;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_overflow;
  assign bcd_out  = r_bcd_out;

endmodule

`default_nettype wire
